// File: rtl/control_unit_pipelined.sv
// RV32IM decode/control stage: combinational decode into registered ID/EX controls,
// with flush/stall handling and a latency sequencer that holds the front end during MUL/DIV.
module control_unit_pipelined #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6,
    parameter bit ENABLE_M   = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       INSTR_VALID,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic [6:0] FUNCT7,
    input  logic       STALL_IN,
    input  logic       FLUSH,
    output logic       VALID_OUT,
    output logic       ILLEGAL,
    output logic       OP1SEL,
    output logic       OP2SEL,
    output logic       MEM_WRITE,
    output logic       MEM_READ,
    output logic       REG_WRITE_EN,
    output logic [1:0] WB_SEL,
    output logic [4:0] ALUOP,
    output logic [2:0] BRANCH_JUMP,
    output logic [2:0] IMM_SEL,
    output logic       MD_BUSY,
    output logic       MD_DONE,
    output logic       STALL_OUT
);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0]       BJ_NONE  = 3'b010;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef struct packed {
        logic       illegal;
        logic       op1_sel;
        logic       op2_sel;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write_en;
        logic [1:0] wb_sel;
        logic [4:0] alu_op;
        logic [2:0] branch_jump;
        logic [2:0] imm_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'({13'd0, BJ_NONE, 3'd0});

    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opimm, is_op;
    logic known_op, m_op, start_m, shift_imm, alu_g;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic valid_q;
    logic [1:0] state;
    logic [CNT_W-1:0] cnt;

    assign is_lui   = (OPCODE == OPC_LUI);
    assign is_auipc = (OPCODE == OPC_AUIPC);
    assign is_jal   = (OPCODE == OPC_JAL);
    assign is_jalr  = (OPCODE == OPC_JALR);
    assign is_br    = (OPCODE == OPC_BR);
    assign is_load  = (OPCODE == OPC_LOAD);
    assign is_store = (OPCODE == OPC_STORE);
    assign is_opimm = (OPCODE == OPC_OPIMM);
    assign is_op    = (OPCODE == OPC_OP);

    assign known_op = is_lui | is_auipc | is_jal | is_jalr | is_br |
                      is_load | is_store | is_opimm | is_op;
    assign m_op     = is_op && (FUNCT7 == 7'b0000001);
    assign start_m  = INSTR_VALID && m_op && ENABLE_M;

    // Shift-immediate encodings (f3 x01) carry FUNCT7 into the ALU op like register ops do.
    assign shift_imm = (FUNCT3[1:0] == 2'b01);
    assign alu_g     = is_op | (is_opimm & shift_imm);

    assign STALL_OUT = STALL_IN || (state == ST_BUSY);

    always_comb begin
        ctrl_d = CTRL_NOP;
        if (INSTR_VALID) begin
            if (!known_op || (m_op && !ENABLE_M)) begin
                ctrl_d.illegal = 1'b1;
            end else begin
                ctrl_d.op1_sel      = is_auipc | is_jal | is_br;
                ctrl_d.op2_sel      = !(is_lui | is_op);
                ctrl_d.mem_read     = is_load;
                ctrl_d.mem_write    = is_store;
                ctrl_d.reg_write_en = is_lui | is_auipc | is_jal | is_jalr |
                                      is_load | is_opimm | is_op;

                if (is_lui)                ctrl_d.wb_sel = 2'b10;
                else if (is_jal | is_jalr) ctrl_d.wb_sel = 2'b11;
                else if (is_load)          ctrl_d.wb_sel = 2'b01;

                if (is_br)                 ctrl_d.branch_jump = FUNCT3;
                else if (is_jal | is_jalr) ctrl_d.branch_jump = 3'b011;

                if (is_opimm | is_jalr) begin
                    if (shift_imm)                ctrl_d.imm_sel = 3'b101;
                    else if (FUNCT3 == 3'b011)    ctrl_d.imm_sel = 3'b111;
                    else                          ctrl_d.imm_sel = 3'b100;
                end else if (is_store)            ctrl_d.imm_sel = 3'b010;
                else if (is_br)                   ctrl_d.imm_sel = 3'b011;
                else if (is_jal)                  ctrl_d.imm_sel = 3'b001;

                if (is_opimm | is_op)
                    ctrl_d.alu_op = {FUNCT3, FUNCT7[5] & alu_g, FUNCT7[0] & alu_g};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            state   <= ST_IDLE;
            cnt     <= '0;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (cnt == '0) state <= ST_DONE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
            // NOTE: the later non-blocking write wins, so an M-op captured in DONE overrides the return to IDLE.
            if (!STALL_OUT) begin
                valid_q <= INSTR_VALID;
                ctrl_q  <= ctrl_d;
                if (start_m) begin
                    state <= ST_BUSY;
                    cnt   <= FUNCT3[2] ? DIV_LAST : MUL_LAST;
                end
            end
        end
    end

    assign VALID_OUT    = valid_q;
    assign ILLEGAL      = ctrl_q.illegal;
    assign OP1SEL       = ctrl_q.op1_sel;
    assign OP2SEL       = ctrl_q.op2_sel;
    assign MEM_WRITE    = ctrl_q.mem_write;
    assign MEM_READ     = ctrl_q.mem_read;
    assign REG_WRITE_EN = ctrl_q.reg_write_en;
    assign WB_SEL       = ctrl_q.wb_sel;
    assign ALUOP        = ctrl_q.alu_op;
    assign BRANCH_JUMP  = ctrl_q.branch_jump;
    assign IMM_SEL      = ctrl_q.imm_sel;
    assign MD_BUSY      = (state == ST_BUSY);
    assign MD_DONE      = (state == ST_DONE);

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Bench for control_unit_pipelined: three configurations driven in parallel, each compared
// every cycle against a behavioural model, plus hand-computed expectations for key scenarios.
module tb_control_unit_pipelined;

    typedef struct packed {
        logic       illegal;
        logic       op1_sel;
        logic       op2_sel;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write_en;
        logic [1:0] wb_sel;
        logic [4:0] alu_op;
        logic [2:0] branch_jump;
        logic [2:0] imm_sel;
    } ctrl_t;

    typedef struct packed {
        logic  valid;
        ctrl_t c;
        logic  busy;
        logic  done;
        logic  stall;
    } out_t;

    localparam ctrl_t NOP = ctrl_t'({13'd0, 3'b010, 3'd0});

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_M      = 7'b0000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, instr_valid, stall_in, flush;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    out_t       dut_out [3];

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: defaults; 1: M-extension disabled; 2: minimum latencies.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic vo, il, o1, o2, mw, mr, rw, mb, md, so;
        logic [1:0] wb;
        logic [4:0] alu;
        logic [2:0] bj, imm;
        control_unit_pipelined #(
            .MUL_CYCLES (g == 2 ? 1 : 4),
            .DIV_CYCLES (g == 2 ? 2 : 32),
            .CNT_W      (g == 2 ? 1 : 6),
            .ENABLE_M   (g != 1)
        ) u_dut (
            .CLK(clk), .RESET(reset), .INSTR_VALID(instr_valid), .OPCODE(opcode),
            .FUNCT3(funct3), .FUNCT7(funct7), .STALL_IN(stall_in), .FLUSH(flush),
            .VALID_OUT(vo), .ILLEGAL(il), .OP1SEL(o1), .OP2SEL(o2), .MEM_WRITE(mw),
            .MEM_READ(mr), .REG_WRITE_EN(rw), .WB_SEL(wb), .ALUOP(alu),
            .BRANCH_JUMP(bj), .IMM_SEL(imm), .MD_BUSY(mb), .MD_DONE(md), .STALL_OUT(so)
        );
        assign dut_out[g] = {vo, il, o1, o2, mw, mr, rw, wb, alu, bj, imm, mb, md, so};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input bit en_m);
        ctrl_t c = NOP;
        bit bad = 1'b0;
        logic [2:0] itype = (f3 == 3'b001 || f3 == 3'b101) ? 3'b101 :
                            (f3 == 3'b011) ? 3'b111 : 3'b100;
        case (op)
            OPC_LUI:   begin c.reg_write_en = 1; c.wb_sel = 2'b10; end
            OPC_AUIPC: begin c.op1_sel = 1; c.op2_sel = 1; c.reg_write_en = 1; end
            OPC_JAL:   begin c.op1_sel = 1; c.op2_sel = 1; c.reg_write_en = 1; c.wb_sel = 2'b11;
                             c.branch_jump = 3'b011; c.imm_sel = 3'b001; end
            OPC_JALR:  begin c.op2_sel = 1; c.reg_write_en = 1; c.wb_sel = 2'b11;
                             c.branch_jump = 3'b011; c.imm_sel = itype; end
            OPC_BR:    begin c.op1_sel = 1; c.op2_sel = 1; c.branch_jump = f3; c.imm_sel = 3'b011; end
            OPC_LOAD:  begin c.op2_sel = 1; c.mem_read = 1; c.reg_write_en = 1; c.wb_sel = 2'b01; end
            OPC_STORE: begin c.op2_sel = 1; c.mem_write = 1; c.imm_sel = 3'b010; end
            OPC_OPIMM: begin c.op2_sel = 1; c.reg_write_en = 1; c.imm_sel = itype;
                             c.alu_op = (itype == 3'b101) ? {f3, f7[5], f7[0]} : {f3, 2'b00}; end
            OPC_OP:    begin if (f7 == F7_M && !en_m) bad = 1'b1;
                             c.reg_write_en = 1; c.alu_op = {f3, f7[5], f7[0]}; end
            default:   bad = 1'b1;
        endcase
        if (bad) begin
            c = NOP;
            c.illegal = 1'b1;
        end
        return c;
    endfunction

    // Model: registered controls plus a count of remaining busy cycles per instance.
    ctrl_t m_c     [3];
    logic  m_valid [3];
    int    m_busy  [3];
    logic  m_done  [3];
    bit    started = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit stalled;
            stalled = stall_in || (m_busy[i] > 0);
            if (reset || flush) begin
                m_valid[i] = 1'b0;
                m_c[i]     = NOP;
                m_busy[i]  = 0;
                m_done[i]  = 1'b0;
            end else begin
                m_done[i] = (m_busy[i] == 1);
                if (m_busy[i] > 0) m_busy[i] = m_busy[i] - 1;
                if (!stalled) begin
                    m_valid[i] = instr_valid;
                    m_c[i]     = instr_valid ? ref_decode(opcode, funct3, funct7, i != 1) : NOP;
                    if (instr_valid && opcode == OPC_OP && funct7 == F7_M && i != 1)
                        m_busy[i] = funct3[2] ? (i == 2 ? 2 : 32) : (i == 2 ? 1 : 4);
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                out_t e;
                e.valid = m_valid[i];
                e.c     = m_c[i];
                e.busy  = (m_busy[i] > 0);
                e.done  = m_done[i];
                e.stall = stall_in || (m_busy[i] > 0);
                check($sformatf("cycle_dut%0d", i), {9'd0, dut_out[i]}, {9'd0, e});
            end
        end
    end

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        instr_valid = v;
        opcode      = op;
        funct3      = f3;
        funct7      = f7;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] opcs [9] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR,
                            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};

    initial begin
        int  n;
        int  k;
        bit  held;

        reset = 1'b1; flush = 1'b0; stall_in = 1'b0;
        drive(1'b1, OPC_OP, 3'b000, 7'd0);
        tick(); tick();
        check("rst_valid", dut_out[0].valid, 0);
        check("rst_bj", dut_out[0].c.branch_jump, 3'b010);
        check("rst_rw", dut_out[0].c.reg_write_en, 0);
        check("rst_stall", dut_out[0].stall, 0);

        reset = 1'b0;
        drive(1'b1, OPC_OPIMM, 3'b000, 7'd0);
        tick();
        check("addi_valid", dut_out[0].valid, 1);
        check("addi_op2", dut_out[0].c.op2_sel, 1);
        check("addi_rw", dut_out[0].c.reg_write_en, 1);
        check("addi_imm", dut_out[0].c.imm_sel, 3'b100);
        check("addi_alu", dut_out[0].c.alu_op, 5'b00000);
        check("addi_wb", dut_out[0].c.wb_sel, 2'b00);

        drive(1'b1, OPC_OPIMM, 3'b101, 7'b0100000);
        tick();
        check("srai_imm", dut_out[0].c.imm_sel, 3'b101);
        check("srai_alu", dut_out[0].c.alu_op, 5'b10110);

        drive(1'b1, OPC_BR, 3'b001, 7'd0);
        tick();
        check("bne_op1", dut_out[0].c.op1_sel, 1);
        check("bne_op2", dut_out[0].c.op2_sel, 1);
        check("bne_bj", dut_out[0].c.branch_jump, 3'b001);
        check("bne_imm", dut_out[0].c.imm_sel, 3'b011);
        check("bne_rw", dut_out[0].c.reg_write_en, 0);

        drive(1'b1, OPC_JALR, 3'b000, 7'd0);
        tick();
        check("jalr_bj", dut_out[0].c.branch_jump, 3'b011);
        check("jalr_wb", dut_out[0].c.wb_sel, 2'b11);
        check("jalr_imm", dut_out[0].c.imm_sel, 3'b100);

        // DIV followed by a MUL that waits on the inputs and is captured in the DONE cycle.
        drive(1'b1, OPC_OP, 3'b100, F7_M);
        tick();
        check("div_alu", dut_out[0].c.alu_op, 5'b10001);
        drive(1'b1, OPC_OP, 3'b000, F7_M);
        n = 0; held = 1'b1;
        while (dut_out[0].stall && n < 100) begin
            n++;
            if (dut_out[0].c.alu_op !== 5'b10001 || dut_out[0].busy !== 1'b1) held = 1'b0;
            tick();
        end
        check("div_stall_cycles", n, 32);
        check("div_held", held, 1);
        check("div_done", dut_out[0].done, 1);
        tick();
        check("mul_alu", dut_out[0].c.alu_op, 5'b00001);
        check("mul_done_cleared", dut_out[0].done, 0);
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        n = 0;
        while (dut_out[0].stall && n < 100) begin
            n++;
            tick();
        end
        check("mul_stall_cycles", n, 4);
        check("mul_done", dut_out[0].done, 1);
        tick();
        check("mul_idle", {dut_out[0].busy, dut_out[0].done}, 2'b00);

        // Abort a DIV in its fifth busy cycle.
        drive(1'b1, OPC_OP, 3'b100, F7_M);
        tick();
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        repeat (4) tick();
        check("flush_pre_busy", dut_out[0].busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", dut_out[0].valid, 0);
        check("flush_busy", dut_out[0].busy, 0);
        check("flush_stall", dut_out[0].stall, 0);
        n = 0;
        repeat (40) begin
            if (dut_out[0].done) n++;
            tick();
        end
        check("flush_no_done", n, 0);

        drive(1'b1, OPC_OPIMM, 3'b000, 7'd0);
        tick();
        check("pre_flush_valid", dut_out[0].valid, 1);
        stall_in = 1'b1; flush = 1'b1;
        tick();
        check("flush_stall_valid", dut_out[0].valid, 0);
        check("flush_stall_rw", dut_out[0].c.reg_write_en, 0);
        check("flush_stall_out", dut_out[0].stall, 1);
        stall_in = 1'b0; flush = 1'b0;

        // Illegal opcode, then held through a three-cycle stall.
        drive(1'b1, 7'b0000000, 3'd0, 7'd0);
        tick();
        check("ill_valid", dut_out[0].valid, 1);
        check("ill_flag", dut_out[0].c.illegal, 1);
        check("ill_rw", dut_out[0].c.reg_write_en, 0);
        check("ill_mw", dut_out[0].c.mem_write, 0);
        stall_in = 1'b1;
        drive(1'b1, OPC_LOAD, 3'b010, 7'd0);
        repeat (3) begin
            tick();
            check("stall_hold_ill", dut_out[0].c.illegal, 1);
            check("stall_hold_mr", dut_out[0].c.mem_read, 0);
        end
        stall_in = 1'b0;
        tick();
        check("load_mr", dut_out[0].c.mem_read, 1);
        check("load_wb", dut_out[0].c.wb_sel, 2'b01);

        drive(1'b1, OPC_OP, 3'b000, F7_M);
        tick();
        check("nom_illegal", dut_out[1].c.illegal, 1);
        check("nom_valid", dut_out[1].valid, 1);
        check("nom_stall", dut_out[1].stall, 0);
        check("lat1_busy", dut_out[2].busy, 1);
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        tick();
        check("lat1_done", dut_out[2].done, 1);
        check("lat1_not_busy", dut_out[2].busy, 0);
        repeat (6) tick();

        repeat (3000) begin
            reset    = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            stall_in = ($urandom_range(0, 4) == 0);
            k = $urandom_range(0, 10);
            opcode = (k < 9) ? opcs[k] : (k == 9) ? OPC_OP : 7'($urandom);
            case ($urandom_range(0, 3))
                0:       funct7 = 7'd0;
                1:       funct7 = 7'b0100000;
                2:       funct7 = F7_M;
                default: funct7 = 7'($urandom);
            endcase
            funct3      = 3'($urandom);
            instr_valid = ($urandom_range(0, 3) != 0);
            tick();
        end

        reset = 1'b0; flush = 1'b0; stall_in = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_unit_pipelined.md
Name: control_unit_pipelined

Overview:
Registered RV32IM decode/control stage that sits between the IF/ID and ID/EX pipeline registers. It decodes OPCODE/FUNCT3/FUNCT7 into datapath controls and registers them with stall and flush support. It flags illegal opcodes. A small FSM sequences multi-cycle M-extension operations (MUL/DIV), stalling the front end until the result is ready.

Parameters:
MUL_CYCLES, 4, EX cycles for MUL/MULH/MULHSU/MULHU (min 1)
DIV_CYCLES, 32, EX cycles for DIV/DIVU/REM/REMU (min 1)
CNT_W, 6, busy-counter width; must hold max(MUL_CYCLES,DIV_CYCLES)-1
ENABLE_M, 1, 0 = M-extension ops decoded as ILLEGAL

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  synchronous, active-high reset
INSTR_VALID  input  1  decode inputs carry a real instruction
OPCODE  input  7  instruction[6:0]
FUNCT3  input  3  instruction[14:12]
FUNCT7  input  7  instruction[31:25]
STALL_IN  input  1  hazard-unit hold request
FLUSH  input  1  branch/jump squash of the decode stage
VALID_OUT  output  1  registered controls belong to a live instruction
ILLEGAL  output  1  registered: valid instruction with unsupported opcode
OP1SEL, OP2SEL, MEM_WRITE, MEM_READ, REG_WRITE_EN  output  1 each  registered controls
WB_SEL  output  2  registered writeback select
ALUOP  output  5  registered ALU op
BRANCH_JUMP  output  3  registered branch/jump code
IMM_SEL  output  3  registered immediate format
MD_BUSY  output  1  M-op sequencer busy
MD_DONE  output  1  one-cycle pulse: M-op result ready
STALL_OUT  output  1  hold PC and IF/ID (combinational)

Behaviour:
- Decode is combinational. All control outputs are registered.
- Opcode classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BR 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011. Any other opcode is ILLEGAL.
- Decoded values:
  - OP1SEL = AUIPC|JAL|BR.
  - OP2SEL = all classes except LUI and OP.
  - MEM_READ = LOAD. MEM_WRITE = STORE.
  - REG_WRITE_EN = LUI|AUIPC|JAL|JALR|LOAD|OPIMM|OP.
- WB_SEL: LUI=10, JAL/JALR=11, LOAD=01, else 00.
- BRANCH_JUMP: BR={FUNCT3}, JAL/JALR=011, else 010 (no branch).
- IMM_SEL:
  - OPIMM/JALR use 1xx: FUNCT3 001/101 → 101, 011 → 111, else 100.
  - STORE=010, BR=011, JAL=001, else 000.
- ALUOP:
  - OPIMM/OP: {FUNCT3, FUNCT7[5]&G, FUNCT7[0]&G}, where G = OP or (OPIMM and IMM_SEL==101).
  - All other classes: 00000.
- M-op: OP class with FUNCT7=0000001 and ENABLE_M=1. FUNCT3[2]=0 is MUL class; FUNCT3[2]=1 is DIV class. With ENABLE_M=0 it is ILLEGAL.
- ILLEGAL instruction: VALID_OUT=1, ILLEGAL=1, all other controls NOP.
- NOP controls: all zero, BRANCH_JUMP=010.
- STALL_OUT = STALL_IN | (state==BUSY).
- Register update priority, evaluated each rising edge:
  1. RESET
  2. FLUSH
  3. STALL_OUT (hold)
  4. capture
- Capture: VALID_OUT ← INSTR_VALID. Controls ← decoded if INSTR_VALID, else NOP.
- Reset/flush values: every output 0 except BRANCH_JUMP=010. FSM goes to IDLE, counter 0.
- FSM states:
  - IDLE: on capture of a valid M-op → BUSY, CNT ← LAT−1 (LAT = MUL_CYCLES or DIV_CYCLES).
  - BUSY: MD_BUSY=1. CNT decrements each cycle. At CNT==0 → DONE.
  - DONE: MD_DONE=1, STALL_OUT=STALL_IN. Capture is allowed this cycle. A captured M-op goes → BUSY, otherwise → IDLE.
- STALL_OUT from the sequencer is high for exactly LAT cycles after capture. Registered controls hold through BUSY.
- STALL_IN during BUSY does not pause CNT.
- STALL_IN in DONE blocks capture; the FSM still returns to IDLE.
- FLUSH during BUSY or DONE aborts: next cycle IDLE, MD_BUSY=0, STALL_OUT=STALL_IN, no MD_DONE.
- RESET mid-operation behaves identically to FLUSH and also clears all registers.
- Inputs presented while STALL_OUT=1 are ignored; upstream must hold them.

Test Plan:
1. RESET high 2 cycles with INSTR_VALID=1, opcode 0110011 → all outputs 0, BRANCH_JUMP=010, STALL_OUT=0. First capture happens on the edge after RESET falls.
2. ADDI (0010011, f3 000) → next cycle VALID_OUT=1, OP2SEL=1, REG_WRITE_EN=1, IMM_SEL=100, ALUOP=00000, WB_SEL=00. Then SRAI (f3 101, f7 0100000) → IMM_SEL=101, ALUOP=10110.
3. BNE (1100011, f3 001) → OP1SEL=1, OP2SEL=1, BRANCH_JUMP=001, IMM_SEL=011, REG_WRITE_EN=0. JALR (1100111) → BRANCH_JUMP=011, WB_SEL=11, IMM_SEL=100.
4. DIV (0110011, f3 100, f7 0000001), DIV_CYCLES=32:
   - ALUOP=10001.
   - STALL_OUT and MD_BUSY high exactly 32 cycles; MD_DONE one pulse after.
   - Controls held.
   - Back-to-back MUL captured in the DONE cycle → 4 stall cycles.
5. FLUSH asserted in 5th BUSY cycle of DIV → next cycle VALID_OUT=0, MD_BUSY=0, STALL_OUT=0, no MD_DONE ever. FLUSH together with STALL_IN=1 → outputs still cleared.
6. Opcode 0000000 valid → VALID_OUT=1, ILLEGAL=1, REG_WRITE_EN=0, MEM_WRITE=0. Then STALL_IN=1 for 3 cycles with new inputs → outputs unchanged. With ENABLE_M=0, MUL → ILLEGAL=1, no stall.
